intr_ctrl: RTL

INTR_CTRL -- requirements
Module: intr_ctrl

---
 rtl/intr_pkg.sv | 17 +
 rtl/intr_prio_enc.sv | 25 ++
 rtl/intr_ctrl.sv | 119 +++++++++++
 3 files changed

// File: rtl/intr_pkg.sv
// Shared types and sizing helpers for the interrupt controller.
package intr_pkg;

  localparam int N_SRC_DEFAULT = 4;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_REQ     = 2'd1,
    ST_SERVICE = 2'd2
  } state_t;

  // Width of a source index; never narrower than one bit.
  function automatic int id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/intr_prio_enc.sv
// Fixed-priority encoder: the lowest-index set bit wins.
module intr_prio_enc
  import intr_pkg::*;
#(
  parameter int N    = N_SRC_DEFAULT,
  parameter int ID_W = id_width(N)
) (
  input  logic [N-1:0]    eligible,
  output logic            valid,
  output logic [ID_W-1:0] idx
);

  // Scan upward and keep the first hit only.
  always_comb begin
    valid = 1'b0;
    idx   = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (eligible[i] && !valid) begin
        valid = 1'b1;
        idx   = ID_W'(i);
      end
    end
  end

endmodule

// File: rtl/intr_ctrl.sv
// Edge-triggered, maskable, fixed-priority interrupt controller with an
// ack/eoi handshake and a request timeout that re-arbitrates.
module intr_ctrl
  import intr_pkg::*;
#(
  parameter  int N_SRC   = N_SRC_DEFAULT,
  parameter  int TIMEOUT = 16,
  localparam int ID_W    = id_width(N_SRC)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_SRC-1:0] src,
  input  logic             mask_we,
  input  logic [N_SRC-1:0] mask_din,
  input  logic             ack,
  input  logic             eoi,
  output logic             intr,
  output logic [ID_W-1:0]  id,
  output logic [N_SRC-1:0] pending
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  state_t             state;
  state_t             state_nxt;
  logic [N_SRC-1:0]   prev_src;
  logic [N_SRC-1:0]   mask;
  logic [N_SRC-1:0]   rise;
  logic [N_SRC-1:0]   eligible;
  logic [N_SRC-1:0]   clr_vec;
  logic [CNT_W-1:0]   cnt;
  logic               win_valid;
  logic [ID_W-1:0]    win_idx;
  logic               timeout_hit;
  logic               latch_id;
  logic               ack_take;
  logic               cnt_clr;

  assign rise        = src & ~prev_src;
  assign eligible    = pending & mask;
  assign timeout_hit = (cnt >= CNT_LAST);

  intr_prio_enc #(
    .N    (N_SRC),
    .ID_W (ID_W)
  ) u_prio (
    .eligible (eligible),
    .valid    (win_valid),
    .idx      (win_idx)
  );

  // State register plus the registered outputs that follow it.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      intr  <= 1'b0;
      id    <= '0;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      intr  <= (state_nxt == ST_REQ);
      if (latch_id) begin
        id <= win_idx;
      end
      if (cnt_clr) begin
        cnt <= '0;
      end else if (state == ST_REQ && cnt != CNT_MAX) begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  // Next-state decision; ack outranks a simultaneous timeout.
  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE: begin
        if (win_valid) state_nxt = ST_REQ;
      end
      ST_REQ: begin
        if (ack)              state_nxt = ST_SERVICE;
        else if (timeout_hit) state_nxt = ST_IDLE;
      end
      ST_SERVICE: begin
        if (eoi) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Control strobes derived from the current state and its inputs.
  always_comb begin
    latch_id = (state == ST_IDLE) && win_valid;
    ack_take = (state == ST_REQ) && ack;
    cnt_clr  = (state != ST_REQ) && (state_nxt == ST_REQ);
    clr_vec  = '0;
    for (int unsigned i = 0; i < N_SRC; i++) begin
      clr_vec[i] = ack_take && (id == ID_W'(i));
    end
  end

  // Edge capture, pending flags and mask; a fresh edge beats an ack clear.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      prev_src <= src;
      pending  <= '0;
      mask     <= '1;
    end else begin
      prev_src <= src;
      pending  <= (pending & ~clr_vec) | rise;
      if (mask_we) begin
        mask <= mask_din;
      end
    end
  end

endmodule
